ram4k_arbiter: RTL and testbench



---
 rtl/ram4k_arbiter_if.sv | 35 +++
 rtl/ram4k_arbiter.sv | 126 ++++++++++++
 tb/tb_ram4k_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram4k_arbiter_if.sv
// ram4k_arbiter requester bus: two request ports plus the shared
// registered read-data return and the clear-in-progress flag.
interface ram4k_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        output req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1,
        input  rdata, busy
    );

    modport slave (
        input  req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1,
        output rdata, busy
    );
endinterface

// File: rtl/ram4k_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared 4096x16 RAM.
// Define RAM4K_ARB_CLEAR_EN to zero the array after reset.
module ram4k_arbiter #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    ram4k_arbiter_if.slave    bus,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out
);

    logic              prio;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata_q;
    logic              arb_en;
    logic              clearing;
    logic              busy_w;
    logic [ADDR_W-1:0] clr_addr;
    logic              g0;
    logic              g1;

`ifdef RAM4K_ARB_CLEAR_EN
    typedef enum logic {
        S_CLEAR,
        S_ARB
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;

    // Clear sequencer: sweep every address once, then hand over to arbitration
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == CNT_LAST) begin
                state <= S_ARB;
            end
        end
    end

    assign busy_w   = (state == S_CLEAR);
    assign clearing = RST_N && (state == S_CLEAR);
    assign arb_en   = RST_N && (state == S_ARB);
    assign clr_addr = clr_cnt;
`else
    assign busy_w   = 1'b0;
    assign clearing = 1'b0;
    assign arb_en   = RST_N;
    assign clr_addr = '0;
`endif

    // Round-robin grant: a lone requester always wins, prio breaks ties
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (arb_en) begin
            g0 = bus.req0 && (!bus.req1 || !prio);
            g1 = bus.req1 && (!bus.req0 || prio);
        end
    end

    // RAM pin mux: clear sweep, then the granted port, else an idle bus
    always_comb begin
        ram_load    = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        if (clearing) begin
            ram_load    = 1'b1;
            ram_address = clr_addr;
            ram_in      = CLEAR_VAL;
        end else if (g0) begin
            ram_load    = bus.we0;
            ram_address = bus.addr0;
            ram_in      = bus.wdata0;
        end else if (g1) begin
            ram_load    = bus.we1;
            ram_address = bus.addr1;
            ram_in      = bus.wdata1;
        end
    end

    // Priority flips to the loser after every grant
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prio <= 1'b0;
        end else if (g0) begin
            prio <= 1'b1;
        end else if (g1) begin
            prio <= 1'b0;
        end
    end

    // Read return: capture RAM output at the granting edge, pulse rvalid
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid0_q <= g0 && !bus.we0;
            rvalid1_q <= g1 && !bus.we1;
            if ((g0 && !bus.we0) || (g1 && !bus.we1)) begin
                rdata_q <= ram_out;
            end
        end
    end

    assign bus.gnt0    = g0;
    assign bus.gnt1    = g1;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = busy_w;

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Self-checking bench for ram4k_arbiter: directed steps plus randomized
// traffic against a transaction-level model of the arbitrated memory.
module tb_ram4k_arbiter;
    localparam int              AW    = 12;
    localparam int              DW    = 16;
    localparam int              DEPTH = 1 << AW;
    localparam logic [DW-1:0]   CVAL  = 16'h0000;
`ifdef RAM4K_ARB_CLEAR_EN
    localparam logic            BUSY_RST = 1'b1;
`else
    localparam logic            BUSY_RST = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    ram4k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [DW-1:0] ram_in;
    logic [DW-1:0] ram_out;
    logic          ram_load;
    logic [AW-1:0] ram_address;

    ram4k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_VAL(CVAL)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .bus         (bus.slave),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .ram_out     (ram_out)
    );

    // RAM4K model: write at the edge, combinational read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge CLK) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end
    assign ram_out = mem[ram_address];

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    bit            known [DEPTH];
    logic          mprio;
    logic [DW-1:0] exp_rdata;
    bit            exp_known;
    logic          exp_rv0;
    logic          exp_rv1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mprio     = 1'b0;
        exp_rdata = '0;
        exp_known = 1'b1;
        exp_rv0   = 1'b0;
        exp_rv1   = 1'b0;
    endtask

    // One arbitrated cycle; called just after a negedge with inputs set
    task automatic cycle(output logic g0, output logic g1);
        logic e0;
        logic e1;
        #1;
        e0 = bus.req0 && (!bus.req1 || (mprio == 1'b0));
        e1 = bus.req1 && !e0;
        chk("gnt0", 32'(bus.gnt0), 32'(e0));
        chk("gnt1", 32'(bus.gnt1), 32'(e1));
        if (e0) begin
            chk("load0", 32'(ram_load), 32'(bus.we0));
            chk("addr0", 32'(ram_address), 32'(bus.addr0));
            if (bus.we0) chk("wdata0", 32'(ram_in), 32'(bus.wdata0));
        end else if (e1) begin
            chk("load1", 32'(ram_load), 32'(bus.we1));
            chk("addr1", 32'(ram_address), 32'(bus.addr1));
            if (bus.we1) chk("wdata1", 32'(ram_in), 32'(bus.wdata1));
        end else begin
            chk("idle_load", 32'(ram_load), 32'd0);
            chk("idle_addr", 32'(ram_address), 32'd0);
            chk("idle_in", 32'(ram_in), 32'd0);
        end
        @(posedge CLK);
        exp_rv0 = e0 && !bus.we0;
        exp_rv1 = e1 && !bus.we1;
        if (e0) begin
            if (bus.we0) begin
                ref_mem[bus.addr0] = bus.wdata0;
                known[bus.addr0]   = 1'b1;
            end else begin
                exp_rdata = ref_mem[bus.addr0];
                exp_known = known[bus.addr0];
            end
            mprio = 1'b1;
        end else if (e1) begin
            if (bus.we1) begin
                ref_mem[bus.addr1] = bus.wdata1;
                known[bus.addr1]   = 1'b1;
            end else begin
                exp_rdata = ref_mem[bus.addr1];
                exp_known = known[bus.addr1];
            end
            mprio = 1'b0;
        end
        #1;
        chk("rvalid0", 32'(bus.rvalid0), 32'(exp_rv0));
        chk("rvalid1", 32'(bus.rvalid1), 32'(exp_rv1));
        if (exp_known) chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
        @(negedge CLK);
        g0 = e0;
        g1 = e1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt0"}, 32'(bus.gnt0), 32'd0);
        chk({tag, "_gnt1"}, 32'(bus.gnt1), 32'd0);
        chk({tag, "_load"}, 32'(ram_load), 32'd0);
        chk({tag, "_rv0"}, 32'(bus.rvalid0), 32'd0);
        chk({tag, "_rv1"}, 32'(bus.rvalid1), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'(BUSY_RST));
    endtask

`ifdef RAM4K_ARB_CLEAR_EN
    // Follow the clear sweep; called right after RST_N rises at a negedge
    task automatic wait_clear();
        int n = 0;
        int bad = 0;
        #1;
        while (bus.busy === 1'b1 && n < DEPTH + 100) begin
            if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 ||
                ram_load !== 1'b1 || ram_address !== n[AW-1:0] ||
                ram_in !== CVAL) bad++;
            n++;
            @(negedge CLK);
        end
        chk("clear_len", 32'(n), 32'(DEPTH));
        chk("clear_seq_bad", 32'(bad), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = CVAL;
            known[i]   = 1'b1;
        end
    endtask
`endif

    // Assumes we are at a negedge; leaves us at a negedge with ARB active
    task automatic do_reset();
        idle_inputs();
        RST_N = 1'b0;
        #1;
        chk_reset_vals("rst");
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
`ifdef RAM4K_ARB_CLEAR_EN
        wait_clear();
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic g0;
        logic g1;
        logic p0;
        logic p1;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        chk_reset_vals("por");

`ifdef RAM4K_ARB_CLEAR_EN
        // Clear with req0 held: no grant until the sweep ends
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h0A7;
        @(negedge CLK);
        RST_N = 1'b1;
        wait_clear();
        cycle(g0, g1);
        chk("clr_first_gnt", 32'(g0), 32'd1);
        chk("clr_rv0", 32'(bus.rvalid0), 32'd1);
        chk("clr_rdata", 32'(bus.rdata), 32'(CVAL));
        bus.req0 = 1'b0;

        // Reset at clear count 2000, then a full restart
        idle_inputs();
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2000) @(negedge CLK);
        #1;
        chk("mid_addr", 32'(ram_address), 32'd2000);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(ram_address), 32'd0);
        chk_reset_vals("mid");
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        wait_clear();
`else
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("busy_off", 32'(bus.busy), 32'd0);
        @(negedge CLK);
`endif

        // Single-port write then read back
        bus.req0 = 1'b1; bus.we0 = 1'b1;
        bus.addr0 = 12'h123; bus.wdata0 = 16'hBEEF;
        cycle(g0, g1);
        chk("wr_gnt0", 32'(g0), 32'd1);
        bus.we0 = 1'b0;
        cycle(g0, g1);
        chk("rd_gnt0", 32'(g0), 32'd1);
        chk("beef_rv0", 32'(bus.rvalid0), 32'd1);
        chk("beef_rdata", 32'(bus.rdata), 32'h0000BEEF);
        bus.req0 = 1'b0;
        cycle(g0, g1);

        // Contention right after reset: strict alternation from port 0
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 12'h010;
        bus.wdata0 = 16'hA000;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h020;
        bus.wdata1 = 16'hB000;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cont_gnt0", 32'(bus.gnt0), 32'((i % 2) == 0));
            chk("cont_gnt1", 32'(bus.gnt1), 32'((i % 2) == 1));
            cycle(g0, g1);
        end
        idle_inputs();

        // Cross-port write at the top address, read by the other port
        bus.req1 = 1'b1; bus.we1 = 1'b1;
        bus.addr1 = 12'hFFF; bus.wdata1 = 16'h1234;
        cycle(g0, g1);
        idle_inputs();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'hFFF;
        cycle(g0, g1);
        chk("x_rdata", 32'(bus.rdata), 32'h00001234);
        chk("x_rv0", 32'(bus.rvalid0), 32'd1);
        chk("x_rv1", 32'(bus.rvalid1), 32'd0);

        // Idle bus: rdata holds the last read
        idle_inputs();
        repeat (4) cycle(g0, g1);
        chk("idle_hold", 32'(bus.rdata), 32'h00001234);

        // Reset while an rvalid pulse is out drops it immediately
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h123;
        cycle(g0, g1);
        chk("pend_rv0", 32'(bus.rvalid0), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("drop_rv0", 32'(bus.rvalid0), 32'd0);
        chk("drop_rdata", 32'(bus.rdata), 32'd0);
        @(negedge CLK);
        do_reset();

        // Randomized traffic honouring the hold-until-grant protocol
        p0 = 1'b0;
        p1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!p0) begin
                bus.req0   = 1'($urandom_range(0, 1));
                bus.we0    = 1'($urandom_range(0, 1));
                bus.addr0  = AW'($urandom_range(0, 15));
                bus.wdata0 = DW'($urandom);
            end
            if (!p1) begin
                bus.req1   = 1'($urandom_range(0, 1));
                bus.we1    = 1'($urandom_range(0, 1));
                bus.addr1  = AW'($urandom_range(0, 15));
                bus.wdata1 = DW'($urandom);
            end
            cycle(g0, g1);
            p0 = bus.req0 && !g0;
            p1 = bus.req1 && !g1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
